// File: rtl/gbuff_out_checker.sv
`default_nettype none
//============================================================================
// Module      : gbuff_out_checker
// Description : Output-path self-check engine. Walks GBUFF_OUT and a golden
//               buffer in lockstep after a GEMM run and compares them lane by
//               lane. It supports straight or reversed lane order, masks the
//               unused lanes of a partial last chunk, keeps a saturating
//               error count and captures the first failing address and lane.
//               Optional build macro: GBUFF_CHK_STOP_ON_ERR_EN. When it is
//               defined, issuing stops at the first registered mismatch and
//               reads already in flight are still compared.
// Revision    : 1.0 - initial release
//============================================================================
module gbuff_out_checker #(
    parameter int LANES  = 5,
    parameter int LANE_W = 8,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1,
    parameter int ERR_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [3:0]                 rows,
    input  logic [3:0]                 cols,
    input  logic                       rev,
    output logic [ADDR_W-1:0]          rd_addr,
    output logic                       rd_en,
    input  logic [LANES*LANE_W-1:0]    out_rdata,
    input  logic [LANES*LANE_W-1:0]    gold_rdata,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [ERR_W-1:0]           err_cnt,
    output logic                       first_err_vld,
    output logic [ADDR_W-1:0]          first_err_addr,
    output logic [$clog2(LANES)-1:0]   first_err_lane
);

    localparam int c_LIDX_W = $clog2(LANES);
    localparam int c_PC_W   = $clog2(LANES + 1);
    // Column counter must hold the largest chunk start plus LANES.
    localparam int c_COL_W  = 5 + c_PC_W;
    localparam int c_SUM_W  = ERR_W + c_PC_W;
    localparam logic [ERR_W-1:0] c_ERR_MAX = '1;

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_ISSUE = 2'd1;
    localparam logic [1:0] c_S_DRAIN = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [3:0]          r_rows;
    logic [3:0]          r_cols;
    logic                r_rev;
    logic [3:0]          r_row;
    logic [c_COL_W-1:0]  r_col;
    logic [ADDR_W-1:0]   r_addr;
    logic [2:0]          r_drain;

    logic                r_pipe_vld  [RD_LAT];
    logic [LANES-1:0]    r_pipe_mask [RD_LAT];
    logic [ADDR_W-1:0]   r_pipe_addr [RD_LAT];

    logic [ERR_W-1:0]    r_err_cnt;
    logic                r_first_vld;
    logic [ADDR_W-1:0]   r_first_addr;
    logic [c_LIDX_W-1:0] r_first_lane;

    logic                w_accept;
    logic                w_empty;
    logic [c_COL_W-1:0]  w_col_next;
    logic                w_row_end;
    logic                w_last_issue;
    logic                w_issuing;
    logic [LANES-1:0]    w_issue_mask;
    logic                w_tail_vld;
    logic [LANES-1:0]    w_tail_mask;
    logic [LANES-1:0]    w_mism;
    logic [c_PC_W-1:0]   w_pc;
    logic [c_LIDX_W-1:0] w_low_lane;
    logic [c_SUM_W-1:0]  w_sum;
    logic [ERR_W-1:0]    w_err_next;
    logic                w_capture;
    logic                w_stop;

    assign w_accept     = start && ((r_state == c_S_IDLE) || (r_state == c_S_DONE));
    assign w_empty      = (rows == 4'd0) || (cols == 4'd0);
    assign w_issuing    = (r_state == c_S_ISSUE);
    assign w_col_next   = r_col + c_COL_W'(LANES);
    assign w_row_end    = (w_col_next >= c_COL_W'(r_cols));
    assign w_last_issue = w_row_end && (r_row == (r_rows - 4'd1));

    assign w_tail_vld   = r_pipe_vld[RD_LAT-1];
    assign w_tail_mask  = r_pipe_mask[RD_LAT-1];

    // Per-lane issue mask and masked compare against the selected golden lane.
    generate
        for (genvar j = 0; j < LANES; j++) begin : g_lane
            logic [LANE_W-1:0] w_gold_lane;
            assign w_issue_mask[j] = ((r_col + c_COL_W'(j)) < c_COL_W'(r_cols));
            assign w_gold_lane = r_rev ? gold_rdata[(LANES-1-j)*LANE_W +: LANE_W]
                                       : gold_rdata[j*LANE_W +: LANE_W];
            assign w_mism[j] = w_tail_vld && w_tail_mask[j] &&
                               (out_rdata[j*LANE_W +: LANE_W] != w_gold_lane);
        end
    endgenerate

    // Popcount of masked mismatches and lowest failing lane of the word.
    always_comb begin
        w_pc       = '0;
        w_low_lane = '0;
        for (int j = LANES - 1; j >= 0; j--) begin
            if (w_mism[j]) begin
                w_pc       = w_pc + c_PC_W'(1);
                w_low_lane = c_LIDX_W'(j);
            end
        end
    end

    assign w_sum      = c_SUM_W'(r_err_cnt) + c_SUM_W'(w_pc);
    assign w_err_next = (w_sum > c_SUM_W'(c_ERR_MAX)) ? c_ERR_MAX : w_sum[ERR_W-1:0];
    assign w_capture  = (|w_mism) && !r_first_vld;

`ifdef GBUFF_CHK_STOP_ON_ERR_EN
    assign w_stop = w_capture;
`else
    assign w_stop = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE, c_S_DONE: begin
                if (start) begin
                    w_state_next = w_empty ? c_S_DONE : c_S_ISSUE;
                end
            end
            c_S_ISSUE: begin
                if (w_last_issue || w_stop) begin
                    w_state_next = c_S_DRAIN;
                end
            end
            c_S_DRAIN: begin
                if (r_drain == 3'(RD_LAT)) begin
                    w_state_next = c_S_DONE;
                end
            end
            default: w_state_next = c_S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Run configuration latch, address/row/column walk and drain timer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rows  <= '0;
            r_cols  <= '0;
            r_rev   <= 1'b0;
            r_row   <= '0;
            r_col   <= '0;
            r_addr  <= '0;
            r_drain <= '0;
        end else begin
            if (w_accept) begin
                r_rows <= rows;
                r_cols <= cols;
                r_rev  <= rev;
                r_row  <= '0;
                r_col  <= '0;
                r_addr <= '0;
            end else if (w_issuing) begin
                r_addr <= r_addr + ADDR_W'(1);
                if (w_row_end) begin
                    r_col <= '0;
                    r_row <= r_row + 4'd1;
                end else begin
                    r_col <= w_col_next;
                end
            end
            r_drain <= (r_state == c_S_DRAIN) ? r_drain + 3'd1 : 3'd0;
        end
    end

    // Valid/mask/address travel alongside the read so they meet the data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe_vld[i]  <= 1'b0;
                r_pipe_mask[i] <= '0;
                r_pipe_addr[i] <= '0;
            end
        end else begin
            r_pipe_vld[0]  <= w_issuing;
            r_pipe_mask[0] <= w_issue_mask;
            r_pipe_addr[0] <= r_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_mask[i] <= r_pipe_mask[i-1];
                r_pipe_addr[i] <= r_pipe_addr[i-1];
            end
        end
    end

    // Error accumulation and first-failure capture; cleared by an accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_cnt    <= '0;
            r_first_vld  <= 1'b0;
            r_first_addr <= '0;
            r_first_lane <= '0;
        end else if (w_accept) begin
            r_err_cnt    <= '0;
            r_first_vld  <= 1'b0;
            r_first_addr <= '0;
            r_first_lane <= '0;
        end else if (w_tail_vld) begin
            r_err_cnt <= w_err_next;
            if (w_capture) begin
                r_first_vld  <= 1'b1;
                r_first_addr <= r_pipe_addr[RD_LAT-1];
                r_first_lane <= w_low_lane;
            end
        end
    end

    assign rd_en          = w_issuing;
    assign rd_addr        = r_addr;
    assign busy           = (r_state == c_S_ISSUE) || (r_state == c_S_DRAIN);
    assign done           = (r_state == c_S_DONE);
    assign pass           = done && (r_err_cnt == '0);
    assign err_cnt        = r_err_cnt;
    assign first_err_vld  = r_first_vld;
    assign first_err_addr = r_first_addr;
    assign first_err_lane = r_first_lane;

endmodule
`default_nettype wire

// File: tb/tb_gbuff_out_checker.sv
`default_nettype none
//============================================================================
// Module      : tb_gbuff_out_checker
// Description : Directed self-checking bench for gbuff_out_checker. Drives two
//               instances from shared stimulus: one with default parameters
//               (RD_LAT=1, ERR_W=16) and one with RD_LAT=2, ERR_W=2.
// Revision    : 1.0 - initial release
//============================================================================
module tb_gbuff_out_checker;

    localparam int LANES  = 5;
    localparam int LANE_W = 8;
    localparam int W      = LANES * LANE_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic [3:0] rows;
    logic [3:0] cols;
    logic       rev;

    logic [W-1:0] out_mem  [0:255];
    logic [W-1:0] gold_mem [0:255];

    logic [W-1:0] a_out_q, a_gold_q;
    logic [W-1:0] b_out_q1, b_gold_q1, b_out_q2, b_gold_q2;

    logic [7:0]  a_rd_addr, b_rd_addr;
    logic        a_rd_en, b_rd_en, a_busy, b_busy, a_done, b_done, a_pass, b_pass;
    logic [15:0] a_err;
    logic [1:0]  b_err;
    logic        a_fev, b_fev;
    logic [7:0]  a_fea, b_fea;
    logic [2:0]  a_fel, b_fel;

    gbuff_out_checker u_a (
        .clk(clk), .rst(rst_n), .start(start), .rows(rows), .cols(cols), .rev(rev),
        .rd_addr(a_rd_addr), .rd_en(a_rd_en), .out_rdata(a_out_q), .gold_rdata(a_gold_q),
        .busy(a_busy), .done(a_done), .pass(a_pass), .err_cnt(a_err),
        .first_err_vld(a_fev), .first_err_addr(a_fea), .first_err_lane(a_fel)
    );

    gbuff_out_checker #(.RD_LAT(2), .ERR_W(2)) u_b (
        .clk(clk), .rst(rst_n), .start(start), .rows(rows), .cols(cols), .rev(rev),
        .rd_addr(b_rd_addr), .rd_en(b_rd_en), .out_rdata(b_out_q2), .gold_rdata(b_gold_q2),
        .busy(b_busy), .done(b_done), .pass(b_pass), .err_cnt(b_err),
        .first_err_vld(b_fev), .first_err_addr(b_fea), .first_err_lane(b_fel)
    );

    // One-cycle read latency buffer model for instance a.
    always @(posedge clk) begin
        if (a_rd_en) begin
            a_out_q  <= out_mem[a_rd_addr];
            a_gold_q <= gold_mem[a_rd_addr];
        end
    end

    // Two-cycle read latency buffer model for instance b.
    always @(posedge clk) begin
        b_out_q1  <= out_mem[b_rd_addr];
        b_gold_q1 <= gold_mem[b_rd_addr];
        b_out_q2  <= b_out_q1;
        b_gold_q2 <= b_gold_q1;
    end

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc, rd_a, rd_b, last_a, last_b;
    int dca, dcb;

    // Advance to the next falling edge and record read activity of that cycle.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (a_rd_en) begin rd_a++; last_a = a_rd_addr; end
        if (b_rd_en) begin rd_b++; last_b = b_rd_addr; end
    endtask

    task automatic kick(input logic [3:0] r, input logic [3:0] c, input logic rv);
        start = 1'b1; rows = r; cols = c; rev = rv;
        cyc = 0; rd_a = 0; rd_b = 0; last_a = -1; last_b = -1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        dca = -1; dcb = -1;
        for (int i = 0; i < 100; i++) begin
            if (a_done && dca < 0) dca = cyc;
            if (b_done && dcb < 0) dcb = cyc;
            if (dca >= 0 && dcb >= 0) break;
            tick();
        end
    endtask

    task automatic fill_rev();
        logic [63:0] t;
        logic [W-1:0] o, g;
        for (int a = 0; a < 256; a++) begin
            t = {$urandom(), $urandom()};
            o = t[W-1:0];
            for (int j = 0; j < LANES; j++) g[(LANES-1-j)*LANE_W +: LANE_W] = o[j*LANE_W +: LANE_W];
            out_mem[a] = o; gold_mem[a] = g;
        end
    endtask

    task automatic fill_same();
        logic [63:0] t;
        for (int a = 0; a < 256; a++) begin
            t = {$urandom(), $urandom()};
            out_mem[a] = t[W-1:0]; gold_mem[a] = t[W-1:0];
        end
    endtask

    task automatic test_reset();
        chk_cnt++; if ({a_busy, a_done, a_pass, a_rd_en, a_fev} !== 5'b0) $display("FAIL rst_flags: got %b want 00000", {a_busy, a_done, a_pass, a_rd_en, a_fev}); else pass_cnt++;
        chk_cnt++; if (a_err !== 16'd0 || a_rd_addr !== 8'd0 || a_fea !== 8'd0 || a_fel !== 3'd0) $display("FAIL rst_vals: err=%0d addr=%0d fea=%0d fel=%0d want 0", a_err, a_rd_addr, a_fea, a_fel); else pass_cnt++;
        chk_cnt++; if ({b_busy, b_done, b_pass, b_err} !== 5'b0) $display("FAIL rst_b: got %b want 00000", {b_busy, b_done, b_pass, b_err}); else pass_cnt++;
    endtask

    task automatic test_match();
        fill_rev();
        kick(4'd5, 4'd5, 1'b1);
        chk_cnt++; if (a_busy !== 1'b1) $display("FAIL match_busy: got %b want 1", a_busy); else pass_cnt++;
        wait_done();
        chk_cnt++; if (dca !== 8) $display("FAIL match_done_a: got cycle %0d want 8", dca); else pass_cnt++;
        chk_cnt++; if (dcb !== 9) $display("FAIL match_done_b: got cycle %0d want 9", dcb); else pass_cnt++;
        chk_cnt++; if (a_pass !== 1'b1 || a_err !== 16'd0) $display("FAIL match_pass: pass=%b err=%0d want 1/0", a_pass, a_err); else pass_cnt++;
        chk_cnt++; if (rd_a !== 5 || last_a !== 4) $display("FAIL match_reads: got %0d last %0d want 5 last 4", rd_a, last_a); else pass_cnt++;
    endtask

    task automatic test_single_err();
        fill_rev();
        out_mem[3][23:16] = ~out_mem[3][23:16];
        kick(4'd5, 4'd5, 1'b1);
        wait_done();
        chk_cnt++; if (a_err !== 16'd1 || a_pass !== 1'b0) $display("FAIL err1_cnt: err=%0d pass=%b want 1/0", a_err, a_pass); else pass_cnt++;
        chk_cnt++; if (a_fev !== 1'b1 || a_fea !== 8'd3 || a_fel !== 3'd2) $display("FAIL err1_first: vld=%b addr=%0d lane=%0d want 1/3/2", a_fev, a_fea, a_fel); else pass_cnt++;
        chk_cnt++; if (b_err !== 2'd1 || b_fea !== 8'd3 || b_fel !== 3'd2) $display("FAIL err1_b: err=%0d addr=%0d lane=%0d want 1/3/2", b_err, b_fea, b_fel); else pass_cnt++;
    endtask

    task automatic test_mask();
        fill_same();
        out_mem[1][39:16] = ~out_mem[1][39:16];
        out_mem[3][39:16] = ~out_mem[3][39:16];
        kick(4'd2, 4'd7, 1'b0);
        wait_done();
        chk_cnt++; if (a_err !== 16'd0 || a_pass !== 1'b1) $display("FAIL mask_err: err=%0d pass=%b want 0/1", a_err, a_pass); else pass_cnt++;
        chk_cnt++; if (rd_a !== 4 || dca !== 7) $display("FAIL mask_reads: reads=%0d done=%0d want 4/7", rd_a, dca); else pass_cnt++;
        out_mem[3][15:8] = ~out_mem[3][15:8];
        kick(4'd2, 4'd7, 1'b0);
        wait_done();
        chk_cnt++; if (a_err !== 16'd1 || a_fea !== 8'd3 || a_fel !== 3'd1) $display("FAIL mask_edge: err=%0d addr=%0d lane=%0d want 1/3/1", a_err, a_fea, a_fel); else pass_cnt++;
    endtask

    task automatic test_empty();
        kick(4'd0, 4'd5, 1'b0);
        wait_done();
        chk_cnt++; if (dca !== 1 || a_pass !== 1'b1 || a_err !== 16'd0) $display("FAIL empty_rows: done=%0d pass=%b err=%0d want 1/1/0", dca, a_pass, a_err); else pass_cnt++;
        chk_cnt++; if (rd_a !== 0 || a_fev !== 1'b0) $display("FAIL empty_rows_rd: reads=%0d fev=%b want 0/0", rd_a, a_fev); else pass_cnt++;
        kick(4'd3, 4'd0, 1'b0);
        wait_done();
        chk_cnt++; if (dca !== 1 || a_pass !== 1'b1 || rd_a !== 0) $display("FAIL empty_cols: done=%0d pass=%b reads=%0d want 1/1/0", dca, a_pass, rd_a); else pass_cnt++;
    endtask

    task automatic test_saturate();
        fill_same();
        out_mem[0] = ~out_mem[0];
        out_mem[2][7:0] = ~out_mem[2][7:0];
        kick(4'd3, 4'd5, 1'b0);
        tick();
        start = 1'b1; rows = 4'd0;
        tick();
        start = 1'b0;
        chk_cnt++; if (a_busy !== 1'b1 || a_done !== 1'b0) $display("FAIL busy_ignore: busy=%b done=%b want 1/0", a_busy, a_done); else pass_cnt++;
        wait_done();
        chk_cnt++; if (dca !== 6 || rd_a !== 3) $display("FAIL busy_ignore_run: done=%0d reads=%0d want 6/3", dca, rd_a); else pass_cnt++;
        chk_cnt++; if (a_err !== 16'd6 || a_fea !== 8'd0 || a_fel !== 3'd0) $display("FAIL sat_a: err=%0d addr=%0d lane=%0d want 6/0/0", a_err, a_fea, a_fel); else pass_cnt++;
        chk_cnt++; if (b_err !== 2'd3 || b_pass !== 1'b0 || dcb !== 7) $display("FAIL sat_b: err=%0d pass=%b done=%0d want 3/0/7", b_err, b_pass, dcb); else pass_cnt++;
    endtask

    task automatic test_rst_mid();
        fill_rev();
        out_mem[0][7:0] = ~out_mem[0][7:0];
        kick(4'd5, 4'd5, 1'b1);
        tick(); tick(); tick();
        chk_cnt++; if (a_err !== 16'd1 || a_busy !== 1'b1) $display("FAIL pre_rst: err=%0d busy=%b want 1/1", a_err, a_busy); else pass_cnt++;
        #1 rst_n = 1'b0;
        #1;
        chk_cnt++; if ({a_busy, a_done, a_rd_en, a_fev, b_busy, b_fev} !== 6'b0 || a_err !== 16'd0 || b_err !== 2'd0 || a_rd_addr !== 8'd0) $display("FAIL mid_rst: flags=%b err=%0d/%0d addr=%0d want all 0", {a_busy, a_done, a_rd_en, a_fev, b_busy, b_fev}, a_err, b_err, a_rd_addr); else pass_cnt++;
        tick(); tick();
        rst_n = 1'b1;
        rd_a = 0;
        for (int i = 0; i < 5; i++) tick();
        chk_cnt++; if (a_done !== 1'b0 || a_busy !== 1'b0 || rd_a !== 0) $display("FAIL post_rst: done=%b busy=%b reads=%0d want 0/0/0", a_done, a_busy, rd_a); else pass_cnt++;
    endtask

    task automatic test_stop();
        fill_rev();
        out_mem[1][7:0] = ~out_mem[1][7:0];
        kick(4'd5, 4'd5, 1'b1);
        wait_done();
        chk_cnt++; if (a_err !== 16'd1 || b_err !== 2'd1 || a_fea !== 8'd1) $display("FAIL stop_err: err=%0d/%0d addr=%0d want 1/1/1", a_err, b_err, a_fea); else pass_cnt++;
`ifdef GBUFF_CHK_STOP_ON_ERR_EN
        chk_cnt++; if (last_b !== 3 || rd_b !== 4) $display("FAIL stop_b: last=%0d reads=%0d want 3/4", last_b, rd_b); else pass_cnt++;
        chk_cnt++; if (last_a !== 2 || rd_a !== 3) $display("FAIL stop_a: last=%0d reads=%0d want 2/3", last_a, rd_a); else pass_cnt++;
`else
        chk_cnt++; if (last_b !== 4 || rd_b !== 5) $display("FAIL walk_b: last=%0d reads=%0d want 4/5", last_b, rd_b); else pass_cnt++;
        chk_cnt++; if (last_a !== 4 || rd_a !== 5) $display("FAIL walk_a: last=%0d reads=%0d want 4/5", last_a, rd_a); else pass_cnt++;
`endif
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; rows = 4'd0; cols = 4'd0; rev = 1'b0;
        cyc = 0; rd_a = 0; rd_b = 0; last_a = -1; last_b = -1;
        fill_same();
        tick(); tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_match();
        test_single_err();
        test_mask();
        test_empty();
        test_saturate();
        test_rst_mid();
        test_stop();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
